// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard/forwarding controller: tracks EX/MEM/WB/WB+1 destinations, drives forwarding
// selects, inserts one bubble on load-use and freezes the whole pipe for multi-cycle ALU ops.
module ex_hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_multi,
  input  logic                flush,
  output logic [1:0]          sel_fw_a,
  output logic [1:0]          sel_fw_b,
  output logic                stall_id,
  output logic                stall_all,
  output logic                ex_valid,
  output logic                mc_start
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                reg_write;
  } stage_t;

  stage_t              ex_q, mem_q, wb_q, wb2_q;
  logic                ex_mem_read;
  logic [REG_BITS-1:0] ex_rs1, ex_rs2;
  logic                ex_use1, ex_use2, ex_multi;
  logic [CNT_W-1:0]    mc_cnt;
  logic                mc_first;
  logic                load_bubble;
  logic                load_multi;

  function automatic logic producer(input stage_t s, input logic [REG_BITS-1:0] rs, input logic used);
    return s.valid & s.reg_write & (s.rd != '0) & (s.rd == rs) & used;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] rs, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_q.valid) begin
      // Youngest producer has priority
      if (producer(mem_q, rs, used))      sel = 2'b01;
      else if (producer(wb_q, rs, used))  sel = 2'b10;
      else if (producer(wb2_q, rs, used)) sel = 2'b11;
    end
    return sel;
  endfunction

  assign sel_fw_a  = fwd_sel(ex_rs1, ex_use1);
  assign sel_fw_b  = fwd_sel(ex_rs2, ex_use2);
  assign stall_all = (mc_cnt != '0);
  assign ex_valid  = ex_q.valid;
  assign mc_start  = mc_first & ex_q.valid & ex_multi;

  assign stall_id = !stall_all & ex_q.valid & ex_mem_read & (ex_q.rd != '0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ex_q.rd)) | (id_uses_rs2 & (id_rs2 == ex_q.rd)));

  assign load_bubble = stall_id | flush | !id_valid;
  assign load_multi  = !stall_all & !load_bubble & id_multi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      wb2_q       <= '0;
      ex_mem_read <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_use1     <= 1'b0;
      ex_use2     <= 1'b0;
      ex_multi    <= 1'b0;
      mc_cnt      <= '0;
      mc_first    <= 1'b0;
    end else begin
      mc_first <= load_multi;
      if (stall_all) begin
        mc_cnt <= mc_cnt - CNT_W'(1);
      end else begin
        wb2_q <= wb_q;
        wb_q  <= mem_q;
        mem_q <= ex_q;
        if (load_bubble) begin
          ex_q        <= '0;
          ex_mem_read <= 1'b0;
          ex_rs1      <= '0;
          ex_rs2      <= '0;
          ex_use1     <= 1'b0;
          ex_use2     <= 1'b0;
          ex_multi    <= 1'b0;
        end else begin
          ex_q        <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write};
          ex_mem_read <= id_mem_read;
          ex_rs1      <= id_rs1;
          ex_rs2      <= id_rs2;
          ex_use1     <= id_uses_rs1;
          ex_use2     <= id_uses_rs2;
          ex_multi    <= id_multi;
        end
        // MC_LAT-1 further EX cycles are spent frozen after the first
        if (load_multi) mc_cnt <= CNT_W'(MC_LAT - 1);
      end
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Randomized bench for ex_hazard_ctrl against an instruction-history model of the pipeline.
module tb_ex_hazard_ctrl;
  localparam int REG_BITS = 5;
  localparam int MC_LAT   = 4;
  localparam int CNT_W    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_multi, flush;
  logic [REG_BITS-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]          sel_fw_a, sel_fw_b;
  logic                stall_id, stall_all, ex_valid, mc_start;

  int checks   = 0;
  int failures = 0;

  ex_hazard_ctrl #(.REG_BITS(REG_BITS), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multi(id_multi),
    .flush(flush), .sel_fw_a(sel_fw_a), .sel_fw_b(sel_fw_b), .stall_id(stall_id),
    .stall_all(stall_all), .ex_valid(ex_valid), .mc_start(mc_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rd; bit rw; bit mr; int rs1; int rs2; bit u1; bit u2; bit mul;
  } ins_t;

  // hist[3] is the instruction in EX, hist[2] MEM, hist[1] WB, hist[0] WB+1
  ins_t hist[$];
  int   freeze_left;
  int   ex_age;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t bubble();
    ins_t b;
    b = '{v: 0, rd: 0, rw: 0, mr: 0, rs1: 0, rs2: 0, u1: 0, u2: 0, mul: 0};
    return b;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (4) hist.push_back(bubble());
    freeze_left = 0;
    ex_age      = 0;
  endtask

  function automatic int exp_sel(input int rs, input bit used);
    ins_t p;
    if (!hist[3].v || !used) return 0;
    for (int d = 1; d <= 3; d++) begin
      p = hist[3-d];
      if (p.v && p.rw && p.rd != 0 && p.rd == rs) return d;
    end
    return 0;
  endfunction

  task automatic drive_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_multi = 0; flush = 0;
  endtask

  task automatic drive_random();
    id_valid     = ($urandom_range(0, 9) < 8);
    id_rs1       = REG_BITS'($urandom_range(0, 7));
    id_rs2       = REG_BITS'($urandom_range(0, 7));
    id_uses_rs1  = ($urandom_range(0, 3) != 0);
    id_uses_rs2  = ($urandom_range(0, 1) != 0);
    id_rd        = REG_BITS'($urandom_range(0, 7));
    id_reg_write = ($urandom_range(0, 3) != 0);
    id_mem_read  = ($urandom_range(0, 9) < 3);
    id_multi     = ($urandom_range(0, 9) == 0);
    flush        = ($urandom_range(0, 9) == 0);
  endtask

  // Called just after a negedge with inputs applied; returns at the following negedge.
  task automatic cycle();
    ins_t e, n;
    bit   frozen, exp_stall;
    #1;
    e      = hist[3];
    frozen = (freeze_left > 0);
    exp_stall = !frozen && e.v && e.mr && e.rd != 0 && id_valid &&
                ((id_uses_rs1 && int'(id_rs1) == e.rd) || (id_uses_rs2 && int'(id_rs2) == e.rd));
    chk("sel_fw_a",  int'(sel_fw_a),  exp_sel(e.rs1, e.u1));
    chk("sel_fw_b",  int'(sel_fw_b),  exp_sel(e.rs2, e.u2));
    chk("stall_id",  int'(stall_id),  int'(exp_stall));
    chk("stall_all", int'(stall_all), int'(frozen));
    chk("ex_valid",  int'(ex_valid),  int'(e.v));
    chk("mc_start",  int'(mc_start),  int'(ex_age == 0 && e.v && e.mul));
    @(posedge clk);
    if (frozen) begin
      freeze_left--;
      ex_age++;
    end else begin
      if (exp_stall || flush || !id_valid) n = bubble();
      else n = '{v: 1, rd: int'(id_rd), rw: id_reg_write, mr: id_mem_read, rs1: int'(id_rs1),
                 rs2: int'(id_rs2), u1: id_uses_rs1, u2: id_uses_rs2, mul: id_multi};
      hist.push_back(n);
      void'(hist.pop_front());
      ex_age = 0;
      if (n.v && n.mul) freeze_left = MC_LAT - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sel_fw_a",  int'(sel_fw_a),  0);
    chk("rst_sel_fw_b",  int'(sel_fw_b),  0);
    chk("rst_stall_id",  int'(stall_id),  0);
    chk("rst_stall_all", int'(stall_all), 0);
    chk("rst_ex_valid",  int'(ex_valid),  0);
    chk("rst_mc_start",  int'(mc_start),  0);
    rst = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      drive_random();
      cycle();
    end

    // Reset in the middle of a multi-cycle op, with two freeze cycles still pending
    drive_idle();
    repeat (6) cycle();
    id_valid = 1; id_multi = 1; id_rd = 3; id_reg_write = 1;
    cycle();
    drive_idle();
    cycle();
    chk("pre_rst_stall_all", int'(stall_all), int'(freeze_left > 0));
    chk("pre_rst_ex_valid",  int'(ex_valid),  int'(hist[3].v));
    rst = 1'b1;
    #1;
    chk("mid_rst_stall_all", int'(stall_all), 0);
    chk("mid_rst_ex_valid",  int'(ex_valid),  0);
    chk("mid_rst_sel_fw_a",  int'(sel_fw_a),  0);
    chk("mid_rst_sel_fw_b",  int'(sel_fw_b),  0);
    chk("mid_rst_mc_start",  int'(mc_start),  0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 300; i++) begin
      drive_random();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
